// File: rtl/req_router.sv
// req_router: routes nodeset send-side requests to nodeset receive-side
// ports. Each request is steered by tag[11:6] and queued in a FIFO per
// destination. Each destination has its own round-robin arbiter, and each
// FIFO presents its head to that destination's receive side. Requests whose
// destination index is out of range are accepted, dropped and flagged.
// Optional macro REQ_ROUTER_STATS_EN enables the forwarded-request counter
// on o_fwd_count; without it o_fwd_count is constant zero.
module req_router #(
  parameter int NUM_NODESETS = 4,
  parameter int NUM_PATHS_DW = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_NODESETS-1:0]              i_src_req_vld,
  input  logic [NUM_NODESETS*NUM_PATHS_DW-1:0] i_src_req_paths,
  input  logic [NUM_NODESETS*12-1:0]           i_src_req_nodenum,
  output logic [NUM_NODESETS-1:0]              o_src_req_ack,
  output logic [NUM_NODESETS-1:0]              o_dst_req_vld,
  output logic [NUM_NODESETS*NUM_PATHS_DW-1:0] o_dst_req_paths,
  output logic [NUM_NODESETS*6-1:0]            o_dst_req_nodenum,
  input  logic [NUM_NODESETS-1:0]              i_dst_req_ack,
  output logic                                 o_idle,
  output logic                                 o_bad_dst,
  output logic [31:0]                          o_fwd_count
);

  localparam int N  = NUM_NODESETS;
  localparam int DW = NUM_PATHS_DW;
  localparam int PW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DW + 6;

  // Per-source decode
  logic [5:0]    src_dst [N];
  logic [N-1:0]  src_bad;

  // Per-destination arbitration and FIFO status
  logic [N-1:0]  cand [N];
  logic [PW-1:0] ptr_reg [N];
  logic [PW-1:0] grant_idx [N];
  logic [N-1:0]  grant_vld;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  logic [N-1:0]  full;
  logic [N-1:0]  empty;
  logic [N-1:0]  nonempty_next;

  logic [N-1:0]  ack_c;
  logic          idle_reg;
  logic          bad_dst_reg;

  genvar gi;

  // Destination index and out-of-range flag for every source
  generate
    for (gi = 0; gi < N; gi++) begin : g_src
      assign src_dst[gi] = i_src_req_nodenum[gi*12+6 +: 6];
      assign src_bad[gi] = ({1'b0, src_dst[gi]} >= 7'(N));
    end
  endgenerate

  generate
    for (gi = 0; gi < N; gi++) begin : g_dst
      logic [EW-1:0]   mem [FIFO_DEPTH];
      logic [AW-1:0]   wr_ptr_reg;
      logic [AW-1:0]   rd_ptr_reg;
      logic [AW:0]     count_reg;
      logic [AW:0]     count_next;
      logic [EW-1:0]   wr_data;
      logic [EW-1:0]   head;

      // Sources currently requesting this destination
      always_comb begin
        cand[gi] = '0;
        for (int s = 0; s < N; s++) begin
          cand[gi][s] = i_src_req_vld[s] & ~src_bad[s] & (src_dst[s] == 6'(gi));
        end
      end

      // Round-robin grant: first candidate at or after the pointer, wrapping
      always_comb begin
        grant_vld[gi] = 1'b0;
        grant_idx[gi] = ptr_reg[gi];
        for (int k = 0; k < N; k++) begin
          if (!grant_vld[gi] && cand[gi][ptr_reg[gi] + PW'(k)]) begin
            grant_vld[gi] = 1'b1;
            grant_idx[gi] = ptr_reg[gi] + PW'(k);
          end
        end
      end

      assign full[gi]  = (count_reg == (AW+1)'(FIFO_DEPTH));
      assign empty[gi] = (count_reg == '0);
      // Full blocks push regardless of a same-cycle pop
      assign push[gi]  = grant_vld[gi] & ~full[gi];
      assign pop[gi]   = ~empty[gi] & i_dst_req_ack[gi];

      assign wr_data = {i_src_req_paths[grant_idx[gi]*DW +: DW],
                        i_src_req_nodenum[grant_idx[gi]*12 +: 6]};

      // Occupancy update from push/pop
      always_comb begin
        count_next = count_reg;
        case ({push[gi], pop[gi]})
          2'b10:   count_next = count_reg + (AW+1)'(1);
          2'b01:   count_next = count_reg - (AW+1)'(1);
          default: count_next = count_reg;
        endcase
      end
      assign nonempty_next[gi] = (count_next != '0);

      // Storage array; contents need no reset since empty gates the outputs
      always_ff @(posedge clk) begin
        if (push[gi]) mem[wr_ptr_reg] <= wr_data;
      end

      // FIFO pointers, occupancy and arbiter pointer
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg  <= '0;
          rd_ptr_reg  <= '0;
          count_reg   <= '0;
          ptr_reg[gi] <= '0;
        end else begin
          count_reg <= count_next;
          if (push[gi]) begin
            wr_ptr_reg  <= wr_ptr_reg + AW'(1);
            ptr_reg[gi] <= grant_idx[gi] + PW'(1);
          end
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
      end

      assign head = empty[gi] ? '0 : mem[rd_ptr_reg];
      assign o_dst_req_vld[gi]              = ~empty[gi];
      assign o_dst_req_paths[gi*DW +: DW]   = head[EW-1:6];
      assign o_dst_req_nodenum[gi*6 +: 6]   = head[5:0];
    end
  endgenerate

  // Source accept: dropped bad-destination requests plus arbiter winners
  always_comb begin
    ack_c = '0;
    for (int s = 0; s < N; s++) begin
      if (i_src_req_vld[s] & src_bad[s]) ack_c[s] = 1'b1;
    end
    for (int d = 0; d < N; d++) begin
      if (push[d]) ack_c[grant_idx[d]] = 1'b1;
    end
  end
  assign o_src_req_ack = ack_c & {N{rst_n}};

  // Idle flag and sticky bad-destination flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_reg    <= 1'b1;
      bad_dst_reg <= 1'b0;
    end else begin
      idle_reg    <= ~(|nonempty_next) & ~(|i_src_req_vld);
      bad_dst_reg <= bad_dst_reg | (|(i_src_req_vld & src_bad));
    end
  end
  assign o_idle    = idle_reg;
  assign o_bad_dst = bad_dst_reg;

`ifdef REQ_ROUTER_STATS_EN
  logic [31:0] fwd_count_reg;
  logic [31:0] fwd_inc;

  // Number of requests entering FIFOs this cycle
  always_comb begin
    fwd_inc = '0;
    for (int d = 0; d < N; d++) begin
      fwd_inc = fwd_inc + 32'(push[d]);
    end
  end

  // Forwarded-request counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fwd_count_reg <= '0;
    else        fwd_count_reg <= fwd_count_reg + fwd_inc;
  end
  assign o_fwd_count = fwd_count_reg;
`else
  assign o_fwd_count = 32'd0;
`endif

endmodule

// File: tb/tb_req_router.sv
// Testbench for req_router (N=4, 16-bit paths, depth 4). Directed phases
// follow the intended usage scenarios; a random phase follows. Every cycle
// is checked against a queue-based reference model.
module tb_req_router;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] p;
    logic [5:0]  t;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     src_vld = '0;
  logic [15:0]      s_paths [N];
  logic [11:0]      s_tag [N];
  logic [N-1:0]     dst_ack = '0;
  logic [N*DW-1:0]  src_paths_bus;
  logic [N*12-1:0]  src_tag_bus;
  logic [N-1:0]     o_src_req_ack;
  logic [N-1:0]     o_dst_req_vld;
  logic [N*DW-1:0]  o_dst_req_paths;
  logic [N*6-1:0]   o_dst_req_nodenum;
  logic             o_idle;
  logic             o_bad_dst;
  logic [31:0]      o_fwd_count;

  // Reference model state
  ent_t             q [N][$];
  int               ptr_m [N];
  bit               bad_m;
  int unsigned      fwd_m;
  bit               prev_vld_m;
  logic [N-1:0]     acked;

  int               n_cmp = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int s = 0; s < N; s++) begin
      src_paths_bus[s*DW +: DW] = s_paths[s];
      src_tag_bus[s*12 +: 12]   = s_tag[s];
    end
  end

  req_router #(.NUM_NODESETS(N), .NUM_PATHS_DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_src_req_vld     (src_vld),
    .i_src_req_paths   (src_paths_bus),
    .i_src_req_nodenum (src_tag_bus),
    .o_src_req_ack     (o_src_req_ack),
    .o_dst_req_vld     (o_dst_req_vld),
    .o_dst_req_paths   (o_dst_req_paths),
    .o_dst_req_nodenum (o_dst_req_nodenum),
    .i_dst_req_ack     (dst_ack),
    .o_idle            (o_idle),
    .o_bad_dst         (o_bad_dst),
    .o_fwd_count       (o_fwd_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      q[d].delete();
      ptr_m[d] = 0;
    end
    bad_m = 0;
    fwd_m = 0;
    prev_vld_m = 0;
    acked = '0;
  endtask

  // Registered outputs against the model
  task automatic check_outputs();
    bit all_empty;
    logic [31:0] fwd_exp;
    all_empty = 1;
    for (int d = 0; d < N; d++) begin
      if (q[d].size() > 0) begin
        all_empty = 0;
        check("dst_vld", 64'(o_dst_req_vld[d]), 64'd1);
        check("dst_paths", 64'(o_dst_req_paths[d*DW +: DW]), 64'(q[d][0].p));
        check("dst_tag", 64'(o_dst_req_nodenum[d*6 +: 6]), 64'(q[d][0].t));
      end else begin
        check("dst_vld", 64'(o_dst_req_vld[d]), 64'd0);
        check("dst_payload_zero", 64'({o_dst_req_paths[d*DW +: DW], o_dst_req_nodenum[d*6 +: 6]}), 64'd0);
      end
    end
    check("idle", 64'(o_idle), 64'(all_empty && !prev_vld_m));
    check("bad_dst", 64'(o_bad_dst), 64'(bad_m));
`ifdef REQ_ROUTER_STATS_EN
    fwd_exp = fwd_m;
`else
    fwd_exp = 32'd0;
`endif
    check("fwd_count", 64'(o_fwd_count), 64'(fwd_exp));
  endtask

  // One clock cycle: inputs already driven just after a posedge
  task automatic step();
    logic [N-1:0] exp_ack;
    bit [N-1:0]   pushd;
    int           win [N];
    bit           bad_now;
    exp_ack = '0;
    pushd   = '0;
    bad_now = 0;
    #1;
    for (int d = 0; d < N; d++) begin
      win[d] = -1;
      for (int k = 0; k < N; k++) begin
        int s;
        s = (ptr_m[d] + k) % N;
        if (win[d] < 0 && src_vld[s] && int'(s_tag[s][11:6]) == d) win[d] = s;
      end
      if (win[d] >= 0 && q[d].size() < DEPTH) begin
        pushd[d] = 1;
        exp_ack[win[d]] = 1'b1;
      end
    end
    for (int s = 0; s < N; s++) begin
      if (src_vld[s] && int'(s_tag[s][11:6]) >= N) begin
        exp_ack[s] = 1'b1;
        bad_now = 1;
      end
    end
    check("src_ack", 64'(o_src_req_ack), 64'(exp_ack));
    acked = exp_ack;
    @(posedge clk);
    for (int d = 0; d < N; d++) begin
      if (dst_ack[d] && q[d].size() > 0) begin
        $display("deliver dst%0d paths=%0d tag=%0d", d, q[d][0].p, q[d][0].t);
        void'(q[d].pop_front());
      end
    end
    for (int d = 0; d < N; d++) begin
      if (pushd[d]) begin
        ent_t e;
        e.p = s_paths[win[d]];
        e.t = s_tag[win[d]][5:0];
        q[d].push_back(e);
        ptr_m[d] = (win[d] + 1) % N;
        fwd_m++;
      end
    end
    bad_m = bad_m | bad_now;
    prev_vld_m = |src_vld;
    #1;
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    src_vld = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int sent;
    int ack_cnt [N];
    for (int s = 0; s < N; s++) begin
      s_paths[s] = '0;
      s_tag[s]   = '0;
    end
    model_reset();

    // Reset state; sources asserting vld during reset must see no ack
    src_vld = 4'hF;
    s_tag[0] = 12'h040;
    s_tag[1] = 12'h140;
    repeat (3) @(posedge clk);
    #1;
    check("rst_src_ack", 64'(o_src_req_ack), 64'd0);
    check("rst_dst_vld", 64'(o_dst_req_vld), 64'd0);
    check("rst_idle", 64'(o_idle), 64'd1);
    check("rst_bad", 64'(o_bad_dst), 64'd0);
    check("rst_fwd", 64'(o_fwd_count), 64'd0);
    src_vld = '0;
    rst_n = 1'b1;
    check_outputs();

    // Single route: src1 -> d3 local 5, paths 7
    dst_ack = 4'hF;
    src_vld = 4'b0010;
    s_tag[1] = 12'h0C5;
    s_paths[1] = 16'd7;
    step();
    check("single_ack", 64'(acked), 64'b0010);
    src_vld = '0;
    step();
    step();
    step();
    $display("phase single route done");

    // Contention: all sources target d1; each withdraws once accepted
    for (int s = 0; s < N; s++) begin
      s_tag[s] = 12'h040 | 12'(s);
      s_paths[s] = 16'(100 + s);
      ack_cnt[s] = 0;
    end
    src_vld = 4'hF;
    for (int c = 0; c < 4; c++) begin
      step();
      check("contend_grant", 64'(acked), 64'(1 << c));
      for (int s = 0; s < N; s++) if (acked[s]) ack_cnt[s]++;
      src_vld = src_vld & ~acked;
    end
    for (int s = 0; s < N; s++) check("contend_once", 64'(ack_cnt[s]), 64'd1);
    idle_steps(4);
    $display("phase contention done");

    // Backpressure: src0 streams 6 requests into d2 while dst2 is stalled
    dst_ack = 4'b1011;
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) dst_ack = 4'hF;
      src_vld = (sent < 6) ? 4'b0001 : 4'b0000;
      s_tag[0] = {6'd2, 6'(sent)};
      s_paths[0] = 16'(200 + sent);
      step();
      if (c == 5) check("bp_held_at_full", 64'(sent), 64'd4);
      if (acked[0]) sent++;
    end
    check("bp_sent", 64'(sent), 64'd6);
    idle_steps(3);
    $display("phase backpressure done");

    // Parallel routes: src0 -> d1, src1 -> d0
    src_vld = 4'b0011;
    s_tag[0] = 12'h04A;
    s_paths[0] = 16'd300;
    s_tag[1] = 12'h00B;
    s_paths[1] = 16'd301;
    step();
    check("parallel_ack", 64'(acked), 64'b0011);
    idle_steps(3);
    $display("phase parallel done");

    // Bad destination
    src_vld = 4'b0100;
    s_tag[2] = 12'h140;
    s_paths[2] = 16'd9;
    step();
    check("bad_ack", 64'(acked), 64'b0100);
    idle_steps(3);
    $display("phase bad destination done");

    // Random traffic with random destination backpressure
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!src_vld[s] || acked[s]) begin
          src_vld[s] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 15) == 0)
            s_tag[s] = {6'($urandom_range(N, 63)), 6'($urandom)};
          else
            s_tag[s] = {6'($urandom_range(0, N-1)), 6'($urandom)};
          s_paths[s] = 16'($urandom);
        end
      end
      for (int d = 0; d < N; d++) dst_ack[d] = ($urandom_range(0, 9) < 6);
      step();
    end
    dst_ack = 4'hF;
    idle_steps(8);
    $display("phase random done");

    // Asynchronous reset with three entries buffered for d3
    dst_ack = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      src_vld = 4'b0001;
      s_tag[0] = {6'd3, 6'(i)};
      s_paths[0] = 16'(400 + i);
      step();
    end
    src_vld = 4'b0001;
    s_tag[0] = 12'h0C7;
    #2;
    check("pre_rst_vld3", 64'(o_dst_req_vld[3]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_dst_vld", 64'(o_dst_req_vld), 64'd0);
    check("async_src_ack", 64'(o_src_req_ack), 64'd0);
    check("async_idle", 64'(o_idle), 64'd1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    src_vld = '0;
    dst_ack = 4'hF;
    rst_n = 1'b1;
    check_outputs();
    idle_steps(3);
    $display("phase async reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute guard against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
